// File: rtl/mem_writeback.sv
// Memory/write-back stage: performs an optional data-memory access over a req/ack
// bus, then commits the result to the register file and/or PC in a single cycle.
module mem_writeback #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned REG_ADDR_WIDTH = 3,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     alu_out,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  logic                      write_rD,
    input  logic                      write_pc,
    input  logic [1:0]                memory_mode,
    input  logic [REG_ADDR_WIDTH-1:0] rd_sel,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_ack,
    output logic                      reg_we,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    output logic [DATA_WIDTH-1:0]     reg_wdata,
    output logic                      pc_we,
    output logic [DATA_WIDTH-1:0]     pc_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      bus_error
);

    localparam int unsigned CNT_WIDTH  = 8;
    localparam logic [1:0]  MODE_READ  = 2'b01;
    localparam logic [1:0]  MODE_WRITE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     sdata_q, sdata_d;
    logic                      wr_rd_q, wr_rd_d;
    logic                      wr_pc_q, wr_pc_d;
    logic [1:0]                mode_q, mode_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic                      mem_req_q, mem_req_d;
    logic                      mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic                      reg_we_q, reg_we_d;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
    logic [DATA_WIDTH-1:0]     reg_wdata_q, reg_wdata_d;
    logic                      pc_we_q, pc_we_d;
    logic [DATA_WIDTH-1:0]     pc_wdata_q, pc_wdata_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      bus_error_q, bus_error_d;

    // State, latched operands and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            sdata_q     <= '0;
            wr_rd_q     <= 1'b0;
            wr_pc_q     <= 1'b0;
            mode_q      <= 2'b00;
            rd_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            pc_we_q     <= 1'b0;
            pc_wdata_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            wr_rd_q     <= wr_rd_d;
            wr_pc_q     <= wr_pc_d;
            mode_q      <= mode_d;
            rd_q        <= rd_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            pc_we_q     <= pc_we_d;
            pc_wdata_q  <= pc_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Next state, then outputs decoded from the next state and next operands.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        wr_rd_d     = wr_rd_q;
        wr_pc_d     = wr_pc_q;
        mode_d      = mode_q;
        rd_d        = rd_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        pc_wdata_d  = pc_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    addr_d  = alu_out;
                    sdata_d = store_data;
                    wr_rd_d = write_rD;
                    wr_pc_d = write_pc;
                    mode_d  = memory_mode;
                    rd_d    = rd_sel;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (memory_mode == MODE_READ || memory_mode == MODE_WRITE) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    if (mode_q == MODE_READ) begin
                        rdata_d = mem_rdata;
                    end
                    cnt_d   = '0;
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    // A zero TIMEOUT never matches, so the access waits forever.
                    if (TIMEOUT != 0 && cnt_d == CNT_WIDTH'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        mem_req_d   = (state_d == S_ACCESS);
        mem_we_d    = (state_d == S_ACCESS) && (mode_d == MODE_WRITE);
        mem_addr_d  = (state_d == S_ACCESS) ? addr_d : '0;
        mem_wdata_d = mem_we_d ? sdata_d : '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_COMMIT);
        reg_we_d    = done_d && wr_rd_d && !err_d;
        pc_we_d     = done_d && wr_pc_d && !err_d;
        bus_error_d = done_d && err_d;

        // Write-back data is loaded only on entry to COMMIT and held afterwards.
        if (done_d) begin
            reg_waddr_d = rd_d;
            reg_wdata_d = (mode_d == MODE_READ) ? rdata_d : addr_d;
            pc_wdata_d  = addr_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign pc_we     = pc_we_q;
    assign pc_wdata  = pc_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Randomized self-checking bench for mem_writeback: a transaction-level model
// predicts every output per cycle; directed cases pin the model with literals.
module tb_mem_writeback;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned TO = 4;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] store_data;
    logic          write_rD;
    logic          write_pc;
    logic [1:0]    memory_mode;
    logic [AW-1:0] rd_sel;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          reg_we;
    logic [AW-1:0] reg_waddr;
    logic [DW-1:0] reg_wdata;
    logic          pc_we;
    logic [DW-1:0] pc_wdata;
    logic          busy;
    logic          done;
    logic          bus_error;

    mem_writeback #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW),
        .TIMEOUT       (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .alu_out    (alu_out),
        .store_data (store_data),
        .write_rD   (write_rD),
        .write_pc   (write_pc),
        .memory_mode(memory_mode),
        .rd_sel     (rd_sel),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .reg_we     (reg_we),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .pc_we      (pc_we),
        .pc_wdata   (pc_wdata),
        .busy       (busy),
        .done       (done),
        .bus_error  (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          reg_we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] rwdata;
        logic          pc_we;
        logic [DW-1:0] pcw;
        logic          busy;
        logic          done;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: write-back values persist between commits.
    logic [AW-1:0] last_waddr = '0;
    logic [DW-1:0] last_rwdata = '0;
    logic [DW-1:0] last_pcw = '0;

    // Observations of the latest commit, used by the literal checks.
    int            req_run = 0;
    int            done_seen = 0;
    int            snap_req = 0;
    logic          snap_reg_we = 1'b0;
    logic [AW-1:0] snap_waddr = '0;
    logic [DW-1:0] snap_rwdata = '0;
    logic          snap_pc_we = 1'b0;
    logic [DW-1:0] snap_pcw = '0;
    logic          snap_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.req = 1'b0; e.we = 1'b0; e.addr = '0; e.wdata = '0;
        e.reg_we = 1'b0; e.waddr = last_waddr; e.rwdata = last_rwdata;
        e.pc_we = 1'b0; e.pcw = last_pcw;
        e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0;
        return e;
    endfunction

    // Compare process: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mem_req",   32'(mem_req),   32'(e.req));
            chk("mem_we",    32'(mem_we),    32'(e.we));
            chk("mem_addr",  32'(mem_addr),  32'(e.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
            chk("reg_we",    32'(reg_we),    32'(e.reg_we));
            chk("reg_waddr", 32'(reg_waddr), 32'(e.waddr));
            chk("reg_wdata", 32'(reg_wdata), 32'(e.rwdata));
            chk("pc_we",     32'(pc_we),     32'(e.pc_we));
            chk("pc_wdata",  32'(pc_wdata),  32'(e.pcw));
            chk("busy",      32'(busy),      32'(e.busy));
            chk("done",      32'(done),      32'(e.done));
            chk("bus_error", 32'(bus_error), 32'(e.err));
        end
        if (mem_req) req_run++;
        else if (!busy) req_run = 0;
        if (done) begin
            done_seen++;
            snap_req    = req_run;
            snap_reg_we = reg_we;
            snap_waddr  = reg_waddr;
            snap_rwdata = reg_wdata;
            snap_pc_we  = pc_we;
            snap_pcw    = pc_wdata;
            snap_err    = bus_error;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        alu_out     = DW'($urandom);
        store_data  = DW'($urandom);
        write_rD    = 1'($urandom);
        write_pc    = 1'($urandom);
        memory_mode = 2'($urandom);
        rd_sel      = AW'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            enable    = 1'b0;
            mem_ack   = 1'($urandom);
            mem_rdata = DW'($urandom);
            rand_ops();
            exp_q.push_back(idle_exp());
        end
    endtask

    // One whole transaction: enable cycle, access cycles, commit, one idle cycle.
    task automatic run_txn(input logic [1:0] mode, input logic [DW-1:0] alu,
                           input logic [DW-1:0] sd, input logic wrd, input logic wpc,
                           input logic [AW-1:0] rd, input int waits,
                           input logic [DW-1:0] rdata, input logic en_in_commit,
                           input logic late_ack);
        exp_t e;
        logic is_mem;
        logic is_read;
        logic timed_out;
        int   n;

        tick();
        enable = 1'b1; alu_out = alu; store_data = sd; write_rD = wrd;
        write_pc = wpc; memory_mode = mode; rd_sel = rd;
        mem_ack = 1'($urandom); mem_rdata = DW'($urandom);
        exp_q.push_back(idle_exp());

        is_read   = (mode == 2'b01);
        is_mem    = is_read || (mode == 2'b10);
        timed_out = 1'b0;
        if (is_mem) begin
            timed_out = (TO != 0) && (waits >= int'(TO));
            n = timed_out ? int'(TO) : waits + 1;
            for (int k = 1; k <= n; k++) begin
                tick();
                enable    = 1'($urandom);
                rand_ops();
                mem_ack   = !timed_out && (k == n);
                mem_rdata = (k == n) ? rdata : DW'($urandom);
                e = idle_exp();
                e.req   = 1'b1;
                e.we    = !is_read;
                e.addr  = alu;
                e.wdata = is_read ? '0 : sd;
                e.busy  = 1'b1;
                exp_q.push_back(e);
            end
        end

        tick();
        enable    = en_in_commit;
        rand_ops();
        mem_ack   = late_ack;
        mem_rdata = DW'($urandom);
        last_waddr  = rd;
        last_rwdata = is_read ? (timed_out ? '0 : rdata) : alu;
        last_pcw    = alu;
        e = idle_exp();
        e.busy   = 1'b1;
        e.done   = 1'b1;
        e.reg_we = wrd && !timed_out;
        e.pc_we  = wpc && !timed_out;
        e.err    = timed_out;
        exp_q.push_back(e);

        tick();
        enable  = 1'b0;
        mem_ack = late_ack;
        exp_q.push_back(idle_exp());
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset = 1'b1; enable = 1'b0; alu_out = '0; store_data = '0; write_rD = 1'b0;
        write_pc = 1'b0; memory_mode = 2'b00; rd_sel = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_reg_wdata", 32'(reg_wdata), 32'd0);
        reset = 1'b0;

        // Async reset mid-access.
        tick();
        enable = 1'b1; memory_mode = 2'b01; alu_out = 16'h00F0;
        tick();
        enable = 1'b0;
        chk("access_mem_req", 32'(mem_req), 32'd1);
        chk("access_mem_addr", 32'(mem_addr), 32'h00F0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;

        // Async reset during commit discards the partial commit.
        tick();
        enable = 1'b1; memory_mode = 2'b00; alu_out = 16'h1234; write_rD = 1'b1; rd_sel = 3'd5;
        tick();
        enable = 1'b0;
        chk("commit_done", 32'(done), 32'd1);
        chk("commit_reg_we", 32'(reg_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_commit_done", 32'(done), 32'd0);
        chk("rst_commit_reg_we", 32'(reg_we), 32'd0);
        chk("rst_commit_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_commit_reg_waddr", 32'(reg_waddr), 32'd0);
        tick();
        reset = 1'b0;
        idle_cycles(2);

        // NOP write-back.
        run_txn(2'b00, 16'h1234, 16'h0, 1'b1, 1'b0, 3'd3, 0, 16'h0, 1'b0, 1'b0);
        chk("nop_reg_we", 32'(snap_reg_we), 32'd1);
        chk("nop_reg_waddr", 32'(snap_waddr), 32'd3);
        chk("nop_reg_wdata", 32'(snap_rwdata), 32'h1234);
        chk("nop_pc_we", 32'(snap_pc_we), 32'd0);
        chk("nop_busy_after", 32'(busy), 32'd0);

        // Zero-wait read.
        run_txn(2'b01, 16'h00F0, 16'h0, 1'b1, 1'b0, 3'd2, 0, 16'hBEEF, 1'b0, 1'b0);
        chk("zw_req_cycles", 32'(snap_req), 32'd1);
        chk("zw_reg_we", 32'(snap_reg_we), 32'd1);
        chk("zw_reg_wdata", 32'(snap_rwdata), 32'hBEEF);

        // Write with three wait states.
        run_txn(2'b10, 16'h0010, 16'hA5A5, 1'b0, 1'b0, 3'd1, 3, 16'h0, 1'b0, 1'b0);
        chk("wr_req_cycles", 32'(snap_req), 32'd4);
        chk("wr_reg_we", 32'(snap_reg_we), 32'd0);
        chk("wr_err", 32'(snap_err), 32'd0);

        // Timeout, then a late ack that must be ignored.
        run_txn(2'b01, 16'h0020, 16'h0, 1'b1, 1'b0, 3'd4, 10, 16'h0, 1'b0, 1'b1);
        chk("to_req_cycles", 32'(snap_req), 32'd4);
        chk("to_err", 32'(snap_err), 32'd1);
        chk("to_reg_we", 32'(snap_reg_we), 32'd0);

        // Jump commit with a second enable arriving during COMMIT.
        d0 = done_seen;
        run_txn(2'b00, 16'h0042, 16'h0, 1'b0, 1'b1, 3'd6, 0, 16'h0, 1'b1, 1'b0);
        idle_cycles(2);
        chk("jmp_pc_we", 32'(snap_pc_we), 32'd1);
        chk("jmp_pc_wdata", 32'(snap_pcw), 32'h0042);
        chk("jmp_reg_we", 32'(snap_reg_we), 32'd0);
        chk("jmp_single_done", 32'(done_seen - d0), 32'd1);

        // Write with write_rD writes alu_out; both strobes together on reserved mode.
        run_txn(2'b10, 16'h0777, 16'h5555, 1'b1, 1'b0, 3'd7, 1, 16'h0, 1'b0, 1'b0);
        chk("wr_rd_wdata", 32'(snap_rwdata), 32'h0777);
        run_txn(2'b11, 16'h0900, 16'h0, 1'b1, 1'b1, 3'd0, 0, 16'h0, 1'b0, 1'b0);
        chk("both_reg_we", 32'(snap_reg_we), 32'd1);
        chk("both_pc_we", 32'(snap_pc_we), 32'd1);

        // Randomized traffic.
        for (int t = 0; t < 250; t++) begin
            run_txn(2'($urandom), DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
                    AW'($urandom), int'($urandom_range(0, 5)), DW'($urandom),
                    1'($urandom), 1'($urandom));
            idle_cycles(int'($urandom_range(0, 2)));
        end
        idle_cycles(2);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Back-end consumer of the ALU result bundle: `out`, `write_rD`, `write_pc` and `memory_mode`.
- Performs the requested data-memory access over a req/ack bus, then commits the result in one cycle, either to the register file and/or to the PC.
- Sits between the ALU stage and the register file / PC register, and reports completion to the control unit.

Parameters:
- DATA_WIDTH, 16, width of data, address and PC.
- REG_ADDR_WIDTH, 3, register file index width.
- TIMEOUT, 255, max ACCESS cycles waiting for mem_ack (range 1..255; 0 disables timeout).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  start strobe; sampled only in IDLE.
- alu_out  in  DATA_WIDTH  ALU result; memory address for READ/WRITE, else write-back value.
- store_data  in  DATA_WIDTH  data for memory WRITE.
- write_rD  in  1  commit to register file.
- write_pc  in  1  commit to PC.
- memory_mode  in  2  00 NOP, 01 READ, 10 WRITE, 11 reserved (treated as NOP).
- rd_sel  in  REG_ADDR_WIDTH  destination register index.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write access.
- mem_addr  out  DATA_WIDTH  access address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- mem_ack  in  1  access complete.
- reg_we  out  1  register file write strobe.
- reg_waddr  out  REG_ADDR_WIDTH  register index.
- reg_wdata  out  DATA_WIDTH  register write data.
- pc_we  out  1  PC load strobe.
- pc_wdata  out  DATA_WIDTH  new PC.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse in COMMIT.
- bus_error  out  1  qualifies done; 1 = access timed out.

Behaviour:
- **Reset (async, immediate):**
  - State = IDLE; timeout counter = 0.
  - All outputs = 0, including mem_req, which drops immediately even mid-access.
  - Latched operands = 0.
- **Outputs:** all are registered or decoded from state/latched registers only. There is no combinational path from any input to any output.
- **IDLE:**
  - On enable=1, latch alu_out, store_data, write_rD, write_pc, memory_mode and rd_sel.
  - NOP or reserved memory_mode → COMMIT.
  - READ or WRITE → ACCESS.
  - enable=0 → stay in IDLE.
- **ACCESS:**
  - mem_req=1; mem_we=1 for WRITE, 0 for READ.
  - mem_addr = latched alu_out; mem_wdata = latched store_data (0 for READ).
  - All bus outputs are held stable for the whole ACCESS state.
  - Each edge with mem_ack=1: capture mem_rdata (READ), clear counter, → COMMIT.
  - Each edge with mem_ack=0: counter increments. When the counter reaches TIMEOUT (TIMEOUT≠0), set a pending error, → COMMIT.
  - mem_req is 0 in COMMIT, so the request deasserts on the edge after ack.
- **COMMIT (exactly one cycle, then → IDLE):**
  - done=1.
  - reg_we = latched write_rD & ~error; reg_waddr = latched rd_sel.
  - reg_wdata = captured mem_rdata for READ, else latched alu_out.
  - pc_we = latched write_pc & ~error; pc_wdata = latched alu_out.
  - bus_error = error.
  - All strobes return to 0 in IDLE. reg_wdata, reg_waddr and pc_wdata hold their last value.
- **Latency, counted in cycles after the enable-sampling edge:**
  - NOP: COMMIT is the first cycle.
  - Memory access with ack on the k-th ACCESS cycle: COMMIT is at cycle k+1.
  - Zero-wait memory (ack in the first ACCESS cycle): 2 cycles.
- **Boundaries:**
  - enable while busy: ignored, no queueing.
  - mem_ack outside ACCESS: ignored, including a late ack after timeout.
  - write_rD and write_pc both set: both strobes fire in the same COMMIT cycle.
  - WRITE with write_rD=1: register is written with alu_out.
  - TIMEOUT=0: waits for ack indefinitely.
  - Reset during COMMIT: done and strobes drop immediately; no partial commit is retained.

Test Plan:
1. **Reset mid-access.** Stimulus: reset=1, then enable with READ; assert reset during ACCESS. Required response: all outputs 0; mem_req falls in the same cycle as reset (async).
2. **NOP write-back.** Stimulus: enable with memory_mode=00, alu_out=16'h1234, write_rD=1, rd_sel=3. Required response: the next cycle has reg_we=1, reg_waddr=3, reg_wdata=16'h1234, done=1, pc_we=0; the cycle after has busy=0.
3. **Zero-wait READ.** Stimulus: memory_mode=01, alu_out=16'h00F0; mem_ack=1 and mem_rdata=16'hBEEF in the first ACCESS cycle. Required response: mem_req=1, mem_we=0, mem_addr=16'h00F0 for 1 cycle; reg_wdata=16'hBEEF with reg_we=1 on cycle 2.
4. **WRITE with wait states.** Stimulus: memory_mode=10, alu_out=16'h0010, store_data=16'hA5A5; ack delayed 3 cycles. Required response: mem_req, mem_we, mem_addr and mem_wdata stable for 4 cycles; done on cycle 5; reg_we=0 with write_rD=0.
5. **Timeout and late ack.** Stimulus: TIMEOUT=4, READ, mem_ack held 0; then a late mem_ack. Required response: mem_req high 4 cycles, then COMMIT with done=1, bus_error=1, reg_we=0; the late mem_ack is ignored.
6. **Jump commit and busy enable.** Stimulus: write_pc=1, write_rD=0, alu_out=16'h0042, NOP; a second enable arrives during COMMIT. Required response: pc_we=1, pc_wdata=16'h0042, reg_we=0; the second enable is ignored (not started).
